// File: rtl/nano_ifu.sv
// ---------------------------------------------------------------------------
// nano_ifu -- small in-order instruction fetch unit.
//
// Issues word-address read requests to an instruction memory, buffers the
// returned words with their PCs in a DEPTH-entry FIFO and presents the FIFO
// head to the core. A redirect from the core flushes the buffer, restarts
// fetch at the new PC and discards every response still in flight.
//
// Parameters
//   RESET_PC  fetch word address after reset
//   DEPTH     buffer entries; must be a power of 2 and at least 2
//
// Ports
//   i_clk, i_rst        clock; asynchronous active-high reset
//   i_redirect          flush and refetch from i_redirect_pc
//   i_redirect_pc       new fetch word address
//   o_mem_req           read request (driven from registered state only)
//   o_mem_addr          word address of the request (always fetch_pc)
//   i_mem_gnt           request accepted this cycle
//   i_mem_rvalid        in-order read data valid, >=1 cycle after its grant
//   i_mem_rdata         instruction word
//   o_inst_valid        FIFO head valid
//   o_inst, o_inst_pc   FIFO head instruction and its word address
//   i_inst_ready        core consumes the head this cycle
//
// Handshakes: a transfer happens in a cycle where the producer's valid
// (o_mem_req / o_inst_valid) and the consumer's ready (i_mem_gnt /
// i_inst_ready) are both high at the rising edge. Once raised, o_mem_req and
// o_mem_addr hold until granted; only a redirect may move o_mem_addr.
// ---------------------------------------------------------------------------
module nano_ifu #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  // Architectural state
  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  cnt_t        out_cnt;     // granted, response not yet returned
  cnt_t        drop_cnt;    // responses still to be discarded after a redirect
  cnt_t        fifo_count;
  ptr_t        wr_ptr;
  ptr_t        rd_ptr;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  // Event decode
  logic        issue;
  logic        rsp;
  logic        drop;
  logic        push;
  logic        pop;
  cnt_t        out_cnt_nxt;
  logic [CW:0] inflight;

  // Buffered plus in-flight words never exceed DEPTH, so a push always has a
  // free slot and the FIFO cannot overflow.
  assign inflight  = {1'b0, fifo_count} + {1'b0, out_cnt};
  assign o_mem_req = (inflight < {1'b0, DEPTH_C});
  assign o_mem_addr = fetch_pc;

  assign issue = o_mem_req & i_mem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp   = i_mem_rvalid & (out_cnt != '0);
  assign drop  = rsp & (drop_cnt != '0);
  // A redirect flushes the buffer, so neither the in-cycle response nor the
  // in-cycle pop may touch it.
  assign push  = rsp & (drop_cnt == '0) & ~i_redirect;
  assign pop   = o_inst_valid & i_inst_ready & ~i_redirect;

  // Outstanding count after this cycle: counts this cycle's grant, excludes
  // this cycle's response. On a redirect every one of these is stale.
  assign out_cnt_nxt = out_cnt + cnt_t'(issue) - cnt_t'(rsp);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc   <= RESET_PC;
      resp_pc    <= RESET_PC;
      out_cnt    <= '0;
      drop_cnt   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      out_cnt <= out_cnt_nxt;
      if (i_redirect) begin
        fetch_pc   <= i_redirect_pc;
        resp_pc    <= i_redirect_pc;
        drop_cnt   <= out_cnt_nxt;
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd1;
        if (drop)  drop_cnt <= drop_cnt - cnt_t'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + ptr_t'(1);
          resp_pc <= resp_pc + 32'd1;
        end
        if (pop) rd_ptr <= rd_ptr + ptr_t'(1);
        if (push && !pop) begin
          fifo_count <= fifo_count + cnt_t'(1);
        end else if (pop && !push) begin
          fifo_count <= fifo_count - cnt_t'(1);
        end
      end
    end
  end

  // Buffer storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      inst_mem[wr_ptr] <= i_mem_rdata;
    end
  end

  assign o_inst_valid = (fifo_count != '0);
  assign o_inst       = inst_mem[rd_ptr];
  assign o_inst_pc    = pc_mem[rd_ptr];

endmodule
